// File: rtl/mcu_debug_responder_pkg.sv
// Shared types for the MCU debug responder and its controller: FSM states,
// decoded command codes and the strobe-priority decoder.
package mcu_db_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_RST_PULSE,
    ST_DONE
  } state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_PAUSE,
    CMD_RESUME,
    CMD_RESET,
    CMD_REG_RD,
    CMD_REG_WR,
    CMD_MEM_RD,
    CMD_MEM_WR
  } cmd_e;

  // Highest-priority strobe wins when several are raised together.
  function automatic cmd_e decode_cmd(
    input logic pause,
    input logic resume,
    input logic reset,
    input logic reg_rd,
    input logic reg_wr,
    input logic mem_rd,
    input logic mem_wr
  );
    cmd_e cmd;
    cmd = CMD_NONE;
    if (pause)       cmd = CMD_PAUSE;
    else if (resume) cmd = CMD_RESUME;
    else if (reset)  cmd = CMD_RESET;
    else if (reg_rd) cmd = CMD_REG_RD;
    else if (reg_wr) cmd = CMD_REG_WR;
    else if (mem_rd) cmd = CMD_MEM_RD;
    else if (mem_wr) cmd = CMD_MEM_WR;
    return cmd;
  endfunction

endpackage

// File: rtl/mcu_debug_responder.sv
// Debug-port command responder: pauses/resumes/resets the MCU and performs
// register-file and memory accesses while paused. DB_BYTE_ACCESS_EN adds byte lanes.
module mcu_debug_responder
  import mcu_db_pkg::*;
#(
  parameter int MEM_RD_LAT = 1,
  parameter int RST_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_pause,
  input  logic        i_resume,
  input  logic        i_reset,
  input  logic        i_reg_rd,
  input  logic        i_reg_wr,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  input  logic        i_mem_rw_byte,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_d_in,
  output logic        o_mcu_busy,
  output logic [31:0] o_d_rd,
  output logic        o_cmd_err,
  output logic        o_mcu_hold,
  output logic        o_mcu_rst,
  output logic [4:0]  o_rf_addr,
  output logic [31:0] o_rf_wd,
  output logic        o_rf_we,
  input  logic [31:0] i_rf_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [3:0]  o_mem_be,
  output logic        o_mem_we,
  output logic        o_mem_re,
  input  logic [31:0] i_mem_rdata
);

  state_e           r_state, w_state_next;
  cmd_e             r_cmd, w_cmd_next, w_cmd;
  logic             r_busy, w_busy_next;
  logic [31:0]      r_d_rd, w_d_rd_next;
  logic             r_err, w_err_next;
  logic             r_hold, w_hold_next;
  logic             r_paused, w_paused_next;
  logic             r_mcu_rst, w_mcu_rst_next;
  logic [4:0]       r_rf_addr, w_rf_addr_next;
  logic [31:0]      r_rf_wd, w_rf_wd_next;
  logic             r_rf_we, w_rf_we_next;
  logic [31:0]      r_mem_addr, w_mem_addr_next;
  logic [31:0]      r_mem_wd, w_mem_wd_next;
  logic [3:0]       r_mem_be, w_mem_be_next;
  logic             r_mem_we, w_mem_we_next;
  logic             r_mem_re, w_mem_re_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;

  logic             w_access, w_reject;
  logic [3:0]       w_be_acc;
  logic [31:0]      w_wd_acc;
  logic [31:0]      w_rd_sel;

`ifdef DB_BYTE_ACCESS_EN
  logic             r_byte, w_byte_next;
  logic [1:0]       r_lane, w_lane_next;
  logic [31:0]      w_lane_word;

  assign w_be_acc    = i_mem_rw_byte ? (4'b0001 << i_addr[1:0]) : 4'hF;
  assign w_wd_acc    = i_mem_rw_byte ? {4{i_d_in[7:0]}} : i_d_in;
  assign w_lane_word = i_mem_rdata >> {r_lane, 3'b000};
  assign w_rd_sel    = r_byte ? {24'h0, w_lane_word[7:0]} : i_mem_rdata;
  assign w_byte_next = (r_state == ST_IDLE) ? i_mem_rw_byte : r_byte;
  assign w_lane_next = (r_state == ST_IDLE) ? i_addr[1:0] : r_lane;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte <= 1'b0;
      r_lane <= 2'd0;
    end else begin
      r_byte <= w_byte_next;
      r_lane <= w_lane_next;
    end
  end
`else
  logic w_unused_byte;
  assign w_unused_byte = i_mem_rw_byte;
  assign w_be_acc      = 4'hF;
  assign w_wd_acc      = i_d_in;
  assign w_rd_sel      = i_mem_rdata;
`endif

  assign w_cmd    = decode_cmd(i_pause, i_resume, i_reset, i_reg_rd, i_reg_wr, i_mem_rd, i_mem_wr);
  assign w_access = (w_cmd == CMD_REG_RD) || (w_cmd == CMD_REG_WR) ||
                    (w_cmd == CMD_MEM_RD) || (w_cmd == CMD_MEM_WR);
  // Register accesses only reach 32 registers; anything above is an error.
  assign w_reject = w_access && (!r_paused ||
                    (((w_cmd == CMD_REG_RD) || (w_cmd == CMD_REG_WR)) && (i_addr[31:5] != 27'd0)));

  always_comb begin
    w_state_next    = r_state;
    w_cmd_next      = r_cmd;
    w_busy_next     = r_busy;
    w_d_rd_next     = r_d_rd;
    w_err_next      = r_err;
    w_hold_next     = r_hold;
    w_paused_next   = r_paused;
    w_mcu_rst_next  = r_mcu_rst;
    w_rf_addr_next  = r_rf_addr;
    w_rf_wd_next    = r_rf_wd;
    w_rf_we_next    = 1'b0;
    w_mem_addr_next = r_mem_addr;
    w_mem_wd_next   = r_mem_wd;
    w_mem_be_next   = r_mem_be;
    w_mem_we_next   = 1'b0;
    w_mem_re_next   = 1'b0;
    w_cnt_next      = r_cnt;

    case (r_state)
      ST_IDLE: begin
        if (i_valid && !r_busy && (w_cmd != CMD_NONE)) begin
          w_busy_next     = 1'b1;
          w_err_next      = 1'b0;
          w_cmd_next      = w_cmd;
          w_state_next    = ST_EXEC;
          w_rf_addr_next  = i_addr[4:0];
          w_rf_wd_next    = i_d_in;
          w_mem_addr_next = {i_addr[31:2], 2'b00};
          w_mem_wd_next   = w_wd_acc;
          w_mem_be_next   = w_be_acc;
          if (w_reject) begin
            w_err_next = 1'b1;
            w_cmd_next = CMD_NONE;
          end else begin
            case (w_cmd)
              CMD_PAUSE: begin
                w_hold_next   = 1'b1;
                w_paused_next = 1'b1;
              end
              CMD_RESUME: begin
                w_hold_next   = 1'b0;
                w_paused_next = 1'b0;
              end
              CMD_RESET: begin
                w_mcu_rst_next = 1'b1;
                w_hold_next    = 1'b0;
                w_paused_next  = 1'b0;
                w_cnt_next     = CNT_W'(RST_CYCLES - 1);
                w_state_next   = ST_RST_PULSE;
              end
              CMD_REG_WR: w_rf_we_next = (i_addr[4:0] != 5'd0);
              CMD_MEM_RD: begin
                w_mem_re_next = 1'b1;
                w_cnt_next    = CNT_W'(MEM_RD_LAT);
                w_state_next  = ST_MEM_WAIT;
              end
              CMD_MEM_WR: w_mem_we_next = 1'b1;
              default: ;
            endcase
          end
        end
      end
      ST_EXEC: begin
        if (r_cmd == CMD_REG_RD) w_d_rd_next = i_rf_rdata;
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end
      ST_MEM_WAIT: begin
        // Counter reaches zero on the edge where read data becomes valid.
        if (r_cnt == '0) begin
          w_d_rd_next  = w_rd_sel;
          w_busy_next  = 1'b0;
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_RST_PULSE: begin
        if (r_cnt == '0) begin
          w_mcu_rst_next = 1'b0;
          w_state_next   = ST_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DONE: begin
        w_busy_next  = 1'b0;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_cmd      <= CMD_NONE;
      r_busy     <= 1'b0;
      r_d_rd     <= 32'd0;
      r_err      <= 1'b0;
      r_hold     <= 1'b0;
      r_paused   <= 1'b0;
      r_mcu_rst  <= 1'b0;
      r_rf_addr  <= 5'd0;
      r_rf_wd    <= 32'd0;
      r_rf_we    <= 1'b0;
      r_mem_addr <= 32'd0;
      r_mem_wd   <= 32'd0;
      r_mem_be   <= 4'd0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cmd      <= w_cmd_next;
      r_busy     <= w_busy_next;
      r_d_rd     <= w_d_rd_next;
      r_err      <= w_err_next;
      r_hold     <= w_hold_next;
      r_paused   <= w_paused_next;
      r_mcu_rst  <= w_mcu_rst_next;
      r_rf_addr  <= w_rf_addr_next;
      r_rf_wd    <= w_rf_wd_next;
      r_rf_we    <= w_rf_we_next;
      r_mem_addr <= w_mem_addr_next;
      r_mem_wd   <= w_mem_wd_next;
      r_mem_be   <= w_mem_be_next;
      r_mem_we   <= w_mem_we_next;
      r_mem_re   <= w_mem_re_next;
      r_cnt      <= w_cnt_next;
    end
  end

  assign o_mcu_busy = r_busy;
  assign o_d_rd     = r_d_rd;
  assign o_cmd_err  = r_err;
  assign o_mcu_hold = r_hold;
  assign o_mcu_rst  = r_mcu_rst;
  assign o_rf_addr  = r_rf_addr;
  assign o_rf_wd    = r_rf_wd;
  assign o_rf_we    = r_rf_we;
  assign o_mem_addr = r_mem_addr;
  assign o_mem_wd   = r_mem_wd;
  assign o_mem_be   = r_mem_be;
  assign o_mem_we   = r_mem_we;
  assign o_mem_re   = r_mem_re;

endmodule

// File: tb/tb_mcu_debug_responder.sv
// Directed, table-driven bench for mcu_debug_responder (MEM_RD_LAT=3, RST_CYCLES=4)
// with register-file and 3-stage memory models.
module tb_mcu_debug_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0, pause = 1'b0, resume = 1'b0, reset = 1'b0;
  logic        reg_rd = 1'b0, reg_wr = 1'b0, mem_rd = 1'b0, mem_wr = 1'b0, mem_rw_byte = 1'b0;
  logic [31:0] addr = '0, d_in = '0;
  logic        mcu_busy, cmd_err, mcu_hold, mcu_rst, rf_we, mem_we, mem_re;
  logic [31:0] d_rd, rf_wd, rf_rdata, mem_addr, mem_wd, mem_rdata;
  logic [4:0]  rf_addr;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

`ifdef DB_BYTE_ACCESS_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  mcu_debug_responder #(.MEM_RD_LAT(3), .RST_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_pause(pause), .i_resume(resume),
    .i_reset(reset), .i_reg_rd(reg_rd), .i_reg_wr(reg_wr), .i_mem_rd(mem_rd),
    .i_mem_wr(mem_wr), .i_mem_rw_byte(mem_rw_byte), .i_addr(addr), .i_d_in(d_in),
    .o_mcu_busy(mcu_busy), .o_d_rd(d_rd), .o_cmd_err(cmd_err), .o_mcu_hold(mcu_hold),
    .o_mcu_rst(mcu_rst), .o_rf_addr(rf_addr), .o_rf_wd(rf_wd), .o_rf_we(rf_we),
    .i_rf_rdata(rf_rdata), .o_mem_addr(mem_addr), .o_mem_wd(mem_wd), .o_mem_be(mem_be),
    .o_mem_we(mem_we), .o_mem_re(mem_re), .i_mem_rdata(mem_rdata)
  );

  // Register file: combinational read, clocked write.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
    end else if (rf_we) begin
      rf[rf_addr] <= rf_wd;
    end
  end
  assign rf_rdata = rf[rf_addr];

  // Memory: word at A is {A[15:0], ~A[15:0]}, data valid 3 cycles after mem_re.
  logic [31:0] s1, s2, s3;
  always @(posedge clk) begin
    s1 <= mem_re ? {mem_addr[15:0], ~mem_addr[15:0]} : 32'hBAD0_BAD0;
    s2 <= s1;
    s3 <= s2;
  end
  assign mem_rdata = s3;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [6:0]  strb;   // {pause,resume,reset,reg_rd,reg_wr,mem_rd,mem_wr}
    logic        byt;
    logic [31:0] addr;
    logic [31:0] din;
    int          busy_n;
    logic        err;
    logic        hold;
    int          rfwe_n;
    int          memre_n;
    int          memwe_n;
    int          rst_n;
    logic        chk_drd;
    logic [31:0] drd;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] strb, input logic byt, input logic [31:0] a,
                              input logic [31:0] din, input int busy_n, input logic err,
                              input logic hold, input int rfwe_n, input int memre_n,
                              input int memwe_n, input int rst_n, input logic chk_drd,
                              input logic [31:0] drd);
    vec_t v;
    v.strb = strb; v.byt = byt; v.addr = a; v.din = din; v.busy_n = busy_n;
    v.err = err; v.hold = hold; v.rfwe_n = rfwe_n; v.memre_n = memre_n;
    v.memwe_n = memwe_n; v.rst_n = rst_n; v.chk_drd = chk_drd; v.drd = drd;
    return v;
  endfunction

  logic [31:0] cap_addr, cap_wd;
  logic [3:0]  cap_be;

  task automatic run(input vec_t v, input int idx);
    int  busy_n = 0, rfwe_n = 0, memre_n = 0, memwe_n = 0, rst_n = 0;
    bit  done = 1'b0;
    @(negedge clk);
    {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = v.strb;
    mem_rw_byte = v.byt;
    addr = v.addr;
    d_in = v.din;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = 7'd0;
    mem_rw_byte = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (!mcu_busy) begin
        done = 1'b1;
        break;
      end
      busy_n++;
      if (rf_we)   rfwe_n++;
      if (mem_re)  memre_n++;
      if (mcu_rst) rst_n++;
      if (mem_we) begin
        memwe_n++;
        cap_addr = mem_addr; cap_be = mem_be; cap_wd = mem_wd;
      end
      @(negedge clk);
    end
    chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
    $display("vec %0d strb=%b addr=%h din=%h busy=%0d err=%b hold=%b d_rd=%h",
             idx, v.strb, v.addr, v.din, busy_n, cmd_err, mcu_hold, d_rd);
    chk($sformatf("v%0d busy_cycles", idx), 32'(busy_n), 32'(v.busy_n));
    chk($sformatf("v%0d cmd_err", idx), 32'(cmd_err), 32'(v.err));
    chk($sformatf("v%0d mcu_hold", idx), 32'(mcu_hold), 32'(v.hold));
    chk($sformatf("v%0d rf_we_cycles", idx), 32'(rfwe_n), 32'(v.rfwe_n));
    chk($sformatf("v%0d mem_re_cycles", idx), 32'(memre_n), 32'(v.memre_n));
    chk($sformatf("v%0d mem_we_cycles", idx), 32'(memwe_n), 32'(v.memwe_n));
    chk($sformatf("v%0d mcu_rst_cycles", idx), 32'(rst_n), 32'(v.rst_n));
    if (v.chk_drd) chk($sformatf("v%0d d_rd", idx), d_rd, v.drd);
  endtask

  localparam logic [6:0] P = 7'h40, RS = 7'h20, RT = 7'h10, RR = 7'h08,
                         RW = 7'h04, MR = 7'h02, MW = 7'h01;

  vec_t vecs [18];
  vec_t vpause, vmrd, vrrd;
  logic [31:0] w100, byte_rd;
  int   sre;

  initial begin
    w100    = 32'h0100_FEFF;
    byte_rd = BYTE_EN ? 32'h0000_00FE : w100;
    //            strb  byt addr          din           busy err hold rfwe re we rst chk drd
    vecs[0]  = mk(MR,    0, 32'h100,      32'h0,        1,   1,  0,   0,   0, 0, 0,  1, 32'h0);
    vecs[1]  = mk(RT,    0, 32'h0,        32'h0,        5,   0,  0,   0,   0, 0, 4,  0, 32'h0);
    vecs[2]  = mk(P,     0, 32'h0,        32'h0,        1,   0,  1,   0,   0, 0, 0,  0, 32'h0);
    vecs[3]  = mk(RW,    0, 32'h5,        32'hDEADBEEF, 1,   0,  1,   1,   0, 0, 0,  0, 32'h0);
    vecs[4]  = mk(RR,    0, 32'h5,        32'h0,        1,   0,  1,   0,   0, 0, 0,  1, 32'hDEADBEEF);
    vecs[5]  = mk(RR,    0, 32'h25,       32'h0,        1,   1,  1,   0,   0, 0, 0,  1, 32'hDEADBEEF);
    vecs[6]  = mk(RW,    0, 32'h0,        32'h1234,     1,   0,  1,   0,   0, 0, 0,  0, 32'h0);
    vecs[7]  = mk(RR,    0, 32'h0,        32'h0,        1,   0,  1,   0,   0, 0, 0,  1, 32'h0);
    vecs[8]  = mk(MR,    0, 32'h100,      32'h0,        4,   0,  1,   0,   1, 0, 0,  1, w100);
    vecs[9]  = mk(MW,    1, 32'h103,      32'hAB,       1,   0,  1,   0,   0, 1, 0,  1, w100);
    vecs[10] = mk(MR,    1, 32'h101,      32'h0,        4,   0,  1,   0,   1, 0, 0,  1, byte_rd);
    vecs[11] = mk(P|RR,  0, 32'h5,        32'h0,        1,   0,  1,   0,   0, 0, 0,  1, byte_rd);
    vecs[12] = mk(7'h0,  0, 32'h5,        32'h0,        0,   0,  1,   0,   0, 0, 0,  1, byte_rd);
    vecs[13] = mk(RS,    0, 32'h0,        32'h0,        1,   0,  0,   0,   0, 0, 0,  0, 32'h0);
    vecs[14] = mk(RW,    0, 32'h5,        32'h77,       1,   1,  0,   0,   0, 0, 0,  0, 32'h0);
    vecs[15] = mk(P,     0, 32'h0,        32'h0,        1,   0,  1,   0,   0, 0, 0,  0, 32'h0);
    vecs[16] = mk(RT,    0, 32'h0,        32'h0,        5,   0,  0,   0,   0, 0, 4,  0, 32'h0);
    vecs[17] = mk(RR,    0, 32'h5,        32'h0,        1,   1,  0,   0,   0, 0, 0,  1, byte_rd);

    repeat (3) @(negedge clk);
    chk("rst mcu_busy", 32'(mcu_busy), 32'd0);
    chk("rst d_rd", d_rd, 32'd0);
    chk("rst cmd_err", 32'(cmd_err), 32'd0);
    chk("rst mcu_hold", 32'(mcu_hold), 32'd0);
    chk("rst mcu_rst", 32'(mcu_rst), 32'd0);
    chk("rst strobes", {29'd0, rf_we, mem_we, mem_re}, 32'd0);
    chk("rst mem_be", 32'(mem_be), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst rf_addr", 32'(rf_addr), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run(vecs[i], i);
      if (i == 9) begin
        chk("mem_wr mem_addr", cap_addr, 32'h0000_0100);
        chk("mem_wr mem_be", 32'(cap_be), BYTE_EN ? 32'h8 : 32'hF);
        chk("mem_wr mem_wd", cap_wd, BYTE_EN ? 32'hABAB_ABAB : 32'h0000_00AB);
      end
    end

    // rst asserted while the memory read is still outstanding.
    vpause = mk(P, 0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
    run(vpause, 100);
    @(negedge clk);
    {pause, resume, reset, reg_rd, reg_wr, mem_rd, mem_wr} = MR;
    addr = 32'h200;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    mem_rd = 1'b0;
    chk("abort mem_re issued", 32'(mem_re), 32'd1);
    @(negedge clk);
    chk("abort busy before rst", 32'(mcu_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort mcu_busy", 32'(mcu_busy), 32'd0);
    chk("abort d_rd", d_rd, 32'd0);
    chk("abort mcu_hold", 32'(mcu_hold), 32'd0);
    sre = 0;
    for (int k = 0; k < 6; k++) begin
      if (mem_re || mem_we || rf_we || mcu_busy) sre++;
      @(negedge clk);
    end
    chk("abort no strobes", 32'(sre), 32'd0);
    $display("abort sequence: busy=%b d_rd=%h hold=%b", mcu_busy, d_rd, mcu_hold);
    vrrd = mk(RR, 0, 32'h5, 32'h0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0);
    run(vrrd, 101);
    vmrd = mk(MR, 0, 32'h100, 32'h0, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0);
    run(vmrd, 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
